// File: rtl/muldiv_hilo_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MT/MF moves.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mul0_div1_sel,
   input  logic             is_unsigned,
   input  logic             hilo_mov_op,
   input  logic             hi0_lo1_sel,
   input  logic             mt_sel,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hilo_rd
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   rs_raw;
   logic [WIDTH-1:0]   hi, lo;
   logic               is_div, neg_q, neg_r, div_zero, done_q;

   logic               rs_neg, rt_neg, last_iter, div_ok;
   logic [WIDTH-1:0]   rs_mag, rt_mag, quo, rem;
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] prod;

   assign rs_neg    = !is_unsigned && rs_val[WIDTH-1];
   assign rt_neg    = !is_unsigned && rt_val[WIDTH-1];
   assign rs_mag    = rs_neg ? -rs_val : rs_val;
   assign rt_mag    = rt_neg ? -rt_val : rt_val;
   assign last_iter = (count == CNT_W'(WIDTH - 1));

   // Restoring step: acc holds {partial remainder, dividend bits still to shift in / quotient}.
   assign div_shift = acc[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ok    = !div_diff[WIDTH];

   assign quo  = acc[WIDTH-1:0];
   assign rem  = acc[2*WIDTH-1:WIDTH];
   assign prod = neg_q ? -acc : acc;

`ifndef MULDIV_FAST_MUL_EN
   // Shift-add step: acc holds {partial product high half, remaining multiplier bits}.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
`ifdef MULDIV_FAST_MUL_EN
               state_nxt = mul0_div1_sel ? S_DIV : S_FIX;
`else
               state_nxt = mul0_div1_sel ? S_DIV : S_MUL;
`endif
            end
         end
         S_MUL, S_DIV: if (last_iter) state_nxt = S_FIX;
         S_FIX:        state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         acc      <= '0;
         opnd     <= '0;
         rs_raw   <= '0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  count    <= '0;
                  is_div   <= mul0_div1_sel;
                  neg_q    <= rs_neg ^ rt_neg;
                  neg_r    <= rs_neg;
                  div_zero <= (rt_val == '0);
                  rs_raw   <= rs_val;
                  if (mul0_div1_sel) begin
                     opnd <= rt_mag;
                     acc  <= {{WIDTH{1'b0}}, rs_mag};
                  end else begin
                     opnd <= rs_mag;
`ifdef MULDIV_FAST_MUL_EN
                     acc  <= {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
`else
                     acc  <= {{WIDTH{1'b0}}, rt_mag};
`endif
                  end
               end else if (hilo_mov_op && mt_sel) begin
                  // Illegal start+move decode lands in the branch above, dropping the write.
                  if (hi0_lo1_sel) lo <= rs_val;
                  else             hi <= rs_val;
               end
            end
`ifndef MULDIV_FAST_MUL_EN
            S_MUL: begin
               acc   <= {mul_sum, acc[WIDTH-1:1]};
               count <= count + 1'b1;
            end
`endif
            S_DIV: begin
               acc   <= {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                         acc[WIDTH-2:0], div_ok};
               count <= count + 1'b1;
            end
            S_FIX: begin
               done_q <= 1'b1;
               if (!is_div) begin
                  {hi, lo} <= prod;
               end else if (div_zero) begin
                  hi <= rs_raw;
                  lo <= '1;
               end else begin
                  lo <= neg_q ? -quo : quo;
                  hi <= neg_r ? -rem : rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != S_IDLE);
   assign stall   = busy && (start || hilo_mov_op);
   assign done    = done_q;
   assign hilo_rd = hi0_lo1_sel ? lo : hi;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized self-checking bench for muldiv_hilo_unit against a plain-arithmetic HI/LO model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_hilo_unit;

   localparam int W = 32;

   logic          clk, rst_n;
   logic          start, mul0_div1_sel, is_unsigned;
   logic          hilo_mov_op, hi0_lo1_sel, mt_sel;
   logic [W-1:0]  rs_val, rt_val;
   logic          busy, stall, done;
   logic [W-1:0]  hilo_rd;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [63:0]   exp_q[$];
   logic [W-1:0]  last_hi, last_lo;

   muldiv_hilo_unit #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .mul0_div1_sel (mul0_div1_sel),
      .is_unsigned   (is_unsigned),
      .hilo_mov_op   (hilo_mov_op),
      .hi0_lo1_sel   (hi0_lo1_sel),
      .mt_sel        (mt_sel),
      .rs_val        (rs_val),
      .rt_val        (rt_val),
      .busy          (busy),
      .stall         (stall),
      .done          (done),
      .hilo_rd       (hilo_rd)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: {HI, LO} from plain integer arithmetic
   function automatic logic [63:0] model(input bit div, input bit uns,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
      longint      sa, sb, sq, sr;
      logic [63:0] ua, ub, q, rm, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (!div) begin
         if (uns) r = ua * ub;
         else begin
            sq = sa * sb;
            r  = sq;
         end
      end else if (b == 0) begin
         r = {a, 32'hFFFF_FFFF};
      end else if (uns) begin
         q  = ua / ub;
         rm = ua % ub;
         r  = {rm[31:0], q[31:0]};
      end else begin
         sq = sa / sb;
         sr = sa % sb;
         q  = sq;
         rm = sr;
         r  = {rm[31:0], q[31:0]};
      end
      return r;
   endfunction

   function automatic int exp_lat(input bit div);
`ifdef MULDIV_FAST_MUL_EN
      if (!div) return 1;
`endif
      return W + 1;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // driver tasks (all called at a negedge)
   task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
      hi0_lo1_sel = 1'b0;
      #1 h = hilo_rd;
      hi0_lo1_sel = 1'b1;
      #1 l = hilo_rd;
   endtask

   task automatic move_to(input bit sel_lo, input logic [W-1:0] v);
      hilo_mov_op = 1'b1;
      mt_sel      = 1'b1;
      hi0_lo1_sel = sel_lo;
      rs_val      = v;
      @(negedge clk);
      hilo_mov_op = 1'b0;
      mt_sel      = 1'b0;
      if (sel_lo) last_lo = v;
      else        last_hi = v;
   endtask

   task automatic run_op(input bit div, input bit uns, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit inject, input string tag);
      int          cyc, early;
      logic [63:0] exp;
      logic [W-1:0] h, l;
      exp_q.push_back(model(div, uns, a, b));
      start = 1'b1; mul0_div1_sel = div; is_unsigned = uns;
      rs_val = a; rt_val = b; hilo_mov_op = 1'b0; mt_sel = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      rs_val = W'($urandom);
      rt_val = W'($urandom);
      cyc = 0; early = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         if (done !== 1'b0) early++;
         if (inject) begin
            if (cyc >= 5 && cyc <= 8) begin
               hilo_mov_op = 1'b1; mt_sel = 1'b1; hi0_lo1_sel = 1'b0;
               rs_val = 32'h1234; start = (cyc == 7); mul0_div1_sel = 1'b0;
               #1 check($sformatf("%s_stall_c%0d", tag, cyc), stall, 1);
            end else begin
               hilo_mov_op = 1'b0; start = 1'b0;
               if (cyc == 9) #1 check($sformatf("%s_nostall", tag), stall, 0);
            end
         end
         @(negedge clk);
      end
      hilo_mov_op = 1'b0; mt_sel = 1'b0; start = 1'b0;
      check($sformatf("%s_latency", tag), cyc, exp_lat(div));
      check($sformatf("%s_done", tag), done, 1);
      read_hilo(h, l);
      exp = exp_q.pop_front();
      check($sformatf("%s_hi", tag), h, exp[63:32]);
      check($sformatf("%s_lo", tag), l, exp[31:0]);
      last_hi = exp[63:32];
      last_lo = exp[31:0];
      @(negedge clk);
      check($sformatf("%s_done_once", tag), {31'b0, done} + 32'(early), 0);
   endtask

   initial begin
      logic [W-1:0] h, l;
      int           dcnt, bcnt;
      rst_n = 1'b0; start = 1'b0; mul0_div1_sel = 1'b0; is_unsigned = 1'b0;
      hilo_mov_op = 1'b0; hi0_lo1_sel = 1'b0; mt_sel = 1'b0;
      rs_val = '0; rt_val = '0;
      last_hi = '0; last_lo = '0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      #1 check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      start = 1'b0;
      read_hilo(h, l);
      check("rst_hi", h, 0);
      check("rst_lo", l, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      run_op(0, 0, 32'hFFFF_FFFF, 32'h2, 0, "mult_m1x2");
      run_op(0, 1, 32'hFFFF_FFFF, 32'h2, 0, "multu_max");
      run_op(1, 0, 32'hFFFF_FFF9, 32'h2, 0, "div_neg7");
      run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_op(1, 1, 32'h7, 32'h0, 0, "divu_zero");
      run_op(1, 0, 32'hFFFF_FFF0, 32'h0, 0, "div_zero_neg");
      run_op(0, 0, 32'h8000_0000, 32'h8000_0000, 0, "mult_minmin");

      // MT/START during busy dropped, then a real MTHI lands
      run_op(1, 0, 32'd1000, 32'd7, 1, "div_inject");
      move_to(0, 32'h1234);
      read_hilo(h, l);
      check("mthi_hi", h, 32'h1234);
      check("mthi_lo_kept", l, last_lo);
      move_to(1, 32'hCAFE_F00D);
      read_hilo(h, l);
      check("mtlo_lo", l, 32'hCAFE_F00D);
      check("mtlo_hi_kept", h, 32'h1234);

      // randomized operations interleaved with moves
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            move_to(1'($urandom_range(0, 1)), W'($urandom));
            read_hilo(h, l);
            check($sformatf("rnd_mt_hi_%0d", i), h, last_hi);
            check($sformatf("rnd_mt_lo_%0d", i), l, last_lo);
         end
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(), 0,
                $sformatf("rnd%0d", i));
      end

      // asynchronous reset in the middle of a multiply
      start = 1'b1; mul0_div1_sel = 1'b0; is_unsigned = 1'b0;
      rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      read_hilo(h, l);
      check("arst_hi", h, 0);
      check("arst_lo", l, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0; bcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) dcnt++;
         if (busy !== 1'b0) bcnt++;
      end
      check("arst_no_done", dcnt, 0);
      check("arst_no_busy", bcnt, 0);
      run_op(0, 0, 32'hFFFF_FFFD, 32'h0000_0005, 0, "mult_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
